gate_op_arbiter: RTL and testbench

Shares one registered W-bit bitwise logic unit (AND, OR, NAND, NOR, XOR, XNOR) between N requesters. Round-robin arbitration picks one requester, latches its operands and opcode, computes the result, and holds it under a valid/ready handshake until the consumer accepts it. It sits between the lab's requester blocks and the shared gate datapath. It is the single point that sequences and serialises all gate operations.

---
 rtl/gate_op_arbiter.sv | 176 +++++++++++++++++
 tb/tb_gate_op_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin arbiter in front of one shared W-bit bitwise
// logic unit (AND, OR, NAND, NOR, XOR, XNOR). One operation runs at a time.
// Each operation goes through three steps: grant and latch, compute, then hold
// the result until the consumer accepts it.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   req        : per-requester request level
//   op         : 3-bit opcode per requester, requester i at op[3i+2:3i]
//   a, b       : W-bit operands per requester, requester i at [W*i+W-1:W*i]
//   gnt        : one-hot acceptance pulse lasting one cycle
//   y, y_id    : result and index of the requester that owns it
//   y_err      : result came from an illegal opcode (6/7); y is then 0
//   y_valid    : result valid; y_ready accepts it (y_ready matters only in HOLD)
//   busy       : high whenever the FSM is not IDLE
module gate_op_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_REQ-1:0]                   req,
    input  logic [3*N_REQ-1:0]                 op,
    input  logic [W*N_REQ-1:0]                 a,
    input  logic [W*N_REQ-1:0]                 b,
    output logic [N_REQ-1:0]                   gnt,
    output logic [W-1:0]                       y,
    output logic [$clog2(N_REQ)-1:0]           y_id,
    output logic                               y_err,
    output logic                               y_valid,
    input  logic                               y_ready,
    output logic                               busy
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [2:0]          op_q, op_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [W-1:0]        y_q, y_d;
    logic [ID_W-1:0]     y_id_q, y_id_d;
    logic                y_err_q, y_err_d;
    logic                y_valid_q, y_valid_d;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic [ID_W-1:0]     cand;
    logic [2:0]          sel_op;
    logic [W-1:0]        sel_a, sel_b;
    logic [W-1:0]        res_c;

    // Round-robin search: first set req bit at or after ptr, wrapping modulo N_REQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = ID_W'((int'(ptr_q) + k) % int'(N_REQ));
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Operand/opcode mux for the winner
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_idx == ID_W'(i)) begin
                sel_op = op[3*i +: 3];
                sel_a  = a[W*i +: W];
                sel_b  = b[W*i +: W];
            end
        end
    end

    // Shared bitwise logic unit; an illegal opcode yields zero
    always_comb begin
        case (op_q)
            3'd0:    res_c = a_q & b_q;
            3'd1:    res_c = a_q | b_q;
            3'd2:    res_c = ~(a_q & b_q);
            3'd3:    res_c = ~(a_q | b_q);
            3'd4:    res_c = a_q ^ b_q;
            3'd5:    res_c = ~(a_q ^ b_q);
            default: res_c = '0;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        y_d       = y_q;
        y_id_d    = y_id_q;
        y_err_d   = y_err_q;
        y_valid_d = y_valid_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d   = N_REQ'(1) << win_idx;
                    op_d    = sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    id_d    = win_idx;
                    ptr_d   = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                y_d       = res_c;
                y_id_d    = id_q;
                y_err_d   = (op_q > 3'd5);
                y_valid_d = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            y_q       <= '0;
            y_id_q    <= '0;
            y_err_q   <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= id_d;
            y_q       <= y_d;
            y_id_q    <= y_id_d;
            y_err_q   <= y_err_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign gnt     = gnt_q;
    assign y       = y_q;
    assign y_id    = y_id_q;
    assign y_err   = y_err_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed bench for gate_op_arbiter (N_REQ=4, W=8). Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_gate_op_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [3*N-1:0]   op;
    logic [W*N-1:0]   a;
    logic [W*N-1:0]   b;
    logic [N-1:0]     gnt;
    logic [W-1:0]     y;
    logic [1:0]       y_id;
    logic             y_err;
    logic             y_valid;
    logic             y_ready;
    logic             busy;

    int checks = 0;
    int errors = 0;

    gate_op_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .op      (op),
        .a       (a),
        .b       (b),
        .gnt     (gnt),
        .y       (y),
        .y_id    (y_id),
        .y_err   (y_err),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i, input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
        op[3*i +: 3] = o;
        a[W*i +: W]  = av;
        b[W*i +: W]  = bv;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt"},     32'(gnt),     32'h0);
        chk({tag, ".y"},       32'(y),       32'h0);
        chk({tag, ".y_id"},    32'(y_id),    32'h0);
        chk({tag, ".y_err"},   32'(y_err),   32'h0);
        chk({tag, ".y_valid"}, 32'(y_valid), 32'h0);
        chk({tag, ".busy"},    32'(busy),    32'h0);
    endtask

    // One isolated operation from requester i with y_ready high throughout
    task automatic single_op(input string tag, input int i, input logic [2:0] o,
                             input logic [7:0] av, input logic [7:0] bv,
                             input logic [7:0] exp_y, input logic exp_err);
        load(i, o, av, bv);
        req = 4'(1 << i);
        step();
        chk({tag, ".gnt"}, 32'(gnt), 32'(1 << i));
        chk({tag, ".busy"}, 32'(busy), 32'h1);
        req = '0;
        step();
        chk({tag, ".gnt_off"}, 32'(gnt), 32'h0);
        chk({tag, ".valid"}, 32'(y_valid), 32'h1);
        chk({tag, ".y"}, 32'(y), 32'(exp_y));
        chk({tag, ".id"}, 32'(y_id), 32'(i));
        chk({tag, ".err"}, 32'(y_err), 32'(exp_err));
        step();
        chk({tag, ".valid_drop"}, 32'(y_valid), 32'h0);
        chk({tag, ".idle"}, 32'(busy), 32'h0);
    endtask

    logic [2:0] sweep_op  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    logic [7:0] sweep_y   [7] = '{8'h0A, 8'hAF, 8'hF5, 8'h50, 8'hA5, 8'h5A, 8'h00};
    logic       sweep_err [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int         rr_order  [6] = '{0, 1, 2, 3, 0, 3};

    initial begin
        logic [7:0] held_y;

        // Reset with random inputs
        rst_n   = 1'b0;
        req     = 4'($urandom);
        op      = 12'($urandom);
        a       = $urandom;
        b       = $urandom;
        y_ready = 1'($urandom);
        repeat (3) step();
        chk_all_zero("reset");

        // First operation after release: requester 2 AND
        y_ready = 1'b1;
        op = '0;
        a  = '0;
        b  = '0;
        req = '0;
        rst_n = 1'b1;
        step();
        chk_all_zero("post_release_idle");
        single_op("first_and", 2, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);

        // Opcode sweep on requester 0
        for (int k = 0; k < 7; k++) begin
            single_op($sformatf("sweep%0d", k), 0, sweep_op[k], 8'hAA, 8'h0F, sweep_y[k], sweep_err[k]);
        end

        // Requester 3 twice in a row; ptr wraps back to 0 each time
        single_op("wrap_a", 3, 3'd1, 8'h12, 8'h40, 8'h52, 1'b0);
        single_op("wrap_b", 3, 3'd4, 8'hFF, 8'h0F, 8'hF0, 1'b0);

        // Round-robin: all requesting, then 1001 after grant 3
        for (int i = 0; i < 4; i++) load(i, 3'd4, 8'(8'h10 * i), 8'h01);
        req = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            step();
            chk($sformatf("rr%0d.gnt", g), 32'(gnt), 32'(1 << rr_order[g]));
            if (g == 3) req = 4'b1001;
            if (g == 5) req = 4'b0000;
            step();
            chk($sformatf("rr%0d.gap_gnt", g), 32'(gnt), 32'h0);
            chk($sformatf("rr%0d.id", g), 32'(y_id), 32'(rr_order[g]));
            chk($sformatf("rr%0d.y", g), 32'(y), 32'((8'h10 * rr_order[g]) ^ 8'h01));
            step();
            chk($sformatf("rr%0d.gap2_gnt", g), 32'(gnt), 32'h0);
            chk($sformatf("rr%0d.valid_drop", g), 32'(y_valid), 32'h0);
        end

        // ptr is 0 now: req=1010 grants requester 1, then backpressure
        y_ready = 1'b0;
        load(1, 3'd4, 8'h3C, 8'hFF);
        req = 4'b1010;
        step();
        chk("bp.gnt", 32'(gnt), 32'b0010);
        req = 4'b1111;
        a   = $urandom;
        b   = $urandom;
        step();
        chk("bp.valid", 32'(y_valid), 32'h1);
        chk("bp.y", 32'(y), 32'hC3);
        held_y = 8'hC3;
        for (int c = 0; c < 10; c++) begin
            a   = $urandom;
            b   = $urandom;
            req = 4'($urandom);
            step();
            chk($sformatf("bp%0d.y", c), 32'(y), 32'(held_y));
            chk($sformatf("bp%0d.id", c), 32'(y_id), 32'h1);
            chk($sformatf("bp%0d.valid", c), 32'(y_valid), 32'h1);
            chk($sformatf("bp%0d.gnt", c), 32'(gnt), 32'h0);
            chk($sformatf("bp%0d.busy", c), 32'(busy), 32'h1);
        end
        req = 4'b1111;
        y_ready = 1'b1;
        step();
        chk("bp.release_valid", 32'(y_valid), 32'h0);
        chk("bp.release_gnt", 32'(gnt), 32'h0);
        chk("bp.release_busy", 32'(busy), 32'h0);
        step();
        chk("bp.next_gnt", 32'(gnt), 32'b0100);
        req = '0;

        // Reset during EXEC aborts the operation
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("midreset_post%0d.valid", c), 32'(y_valid), 32'h0);
        end
        // ptr cleared: all requesting grants requester 0
        req = 4'b1111;
        step();
        chk("midreset.ptr_gnt", 32'(gnt), 32'b0001);
        req = '0;
        step();
        chk("midreset.op_valid", 32'(y_valid), 32'h1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
